// File: rtl/wb_watchdog.sv
// wb_watchdog: Wishbone watchdog timer. A missed or wrong kick raises a fixed-length wdt_rst_o pulse.
// Optional pre-timeout interrupt (PRE register, STATUS[1], irq_o) is built only with WDT_PRETIMEOUT_EN.
module wb_watchdog #(
  parameter int unsigned             COUNT_WIDTH      = 24,
  parameter logic [COUNT_WIDTH-1:0]  DEFAULT_LOAD     = COUNT_WIDTH'(24'hFF_FFFF),
  parameter logic [31:0]             KICK_KEY         = 32'h5A5A_A5A5,
  parameter int unsigned             RST_PULSE_CYCLES = 16
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic [4:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wdt_rst_o,
  output logic        irq_o
);

  localparam int unsigned PW = (RST_PULSE_CYCLES > 1) ? $clog2(RST_PULSE_CYCLES) : 1;
  localparam logic [PW-1:0]          PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);

  logic                   en;
  logic                   lock;
  logic                   force_exp;
  logic [COUNT_WIDTH-1:0] load_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [PW-1:0]          pulse_cnt;
  logic                   pre_flag;
  logic [31:0]            rdata;
`ifdef WDT_PRETIMEOUT_EN
  logic [COUNT_WIDTH-1:0] pre_q;
`endif

  logic       access;
  logic       wr;
  logic [2:0] reg_sel;
  logic       wr_ctrl;
  logic       wr_load;
  logic       wr_kick;
  logic       key_ok;
  logic       valid_kick;
  logic       bad_kick;
  logic       en_rise;
  logic       expire;
  logic       unused_bits;

  // Wishbone: a request is taken when cyc&stb are high and no ack is pending; the write
  // lands on that edge and ack/read data are registered for exactly one cycle after it.
  assign access  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = access & wb_we_i;
  assign reg_sel = wb_adr_i[4:2];
  assign wr_ctrl = wr && (reg_sel == 3'd0);
  assign wr_load = wr && (reg_sel == 3'd1);
  assign wr_kick = wr && (reg_sel == 3'd3);
  assign key_ok  = (wb_dat_i == KICK_KEY);

  assign unused_bits = ^{wb_sel_i, wb_adr_i[1:0]};

  // Kicks are ignored while the reset pulse is out; a wrong key only matters once locked.
  assign valid_kick = wr_kick & key_ok & en & ~wdt_rst_o;
  assign bad_kick   = wr_kick & ~key_ok & lock & en & ~wdt_rst_o;
  assign en_rise    = wr_ctrl & ~lock & ~en & wb_dat_i[0];
  assign expire     = en & (count_q == '0) & ~valid_kick & ~wdt_rst_o;

  always_comb begin
    rdata = '0;
    case (reg_sel)
      3'd0:    rdata = {30'd0, lock, en};
      3'd1:    rdata = 32'(load_q);
      3'd2:    rdata = 32'(count_q);
      3'd4:    rdata = {30'd0, pre_flag, wdt_rst_o};
`ifdef WDT_PRETIMEOUT_EN
      3'd5:    rdata = 32'(pre_q);
`endif
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= access;
      wb_dat_o <= (access && !wb_we_i) ? rdata : '0;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      en     <= 1'b0;
      lock   <= 1'b0;
      load_q <= DEFAULT_LOAD;
    end else if (!lock) begin
      if (wr_ctrl) begin
        en   <= wb_dat_i[0];
        lock <= wb_dat_i[1];
      end
      if (wr_load) begin
        load_q <= wb_dat_i[COUNT_WIDTH-1:0];
      end
    end
  end

  // A locked wrong-key kick zeroes COUNT one edge later, so expiry follows on the edge after.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      count_q   <= DEFAULT_LOAD;
      wdt_rst_o <= 1'b0;
      pulse_cnt <= '0;
      force_exp <= 1'b0;
    end else begin
      force_exp <= bad_kick;
      if (wdt_rst_o) begin
        if (pulse_cnt == '0) begin
          wdt_rst_o <= 1'b0;
        end else begin
          pulse_cnt <= pulse_cnt - PW'(1);
        end
      end else if (expire) begin
        wdt_rst_o <= 1'b1;
        pulse_cnt <= PULSE_LAST;
      end
      if (!wdt_rst_o) begin
        if (en_rise || valid_kick || expire) begin
          count_q <= load_q;
        end else if (force_exp) begin
          count_q <= '0;
        end else if (en && (count_q != '0)) begin
          count_q <= count_q - CNT_ONE;
        end
      end
    end
  end

`ifdef WDT_PRETIMEOUT_EN
  logic wr_pre;
  logic wr_status;
  assign wr_pre    = wr && (reg_sel == 3'd5);
  assign wr_status = wr && (reg_sel == 3'd4);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      pre_q    <= '0;
      pre_flag <= 1'b0;
    end else begin
      if (wr_pre) begin
        pre_q <= wb_dat_i[COUNT_WIDTH-1:0];
      end
      if (en && (count_q == pre_q) && (pre_q != '0)) begin
        pre_flag <= 1'b1;
      end else if (wr_status && wb_dat_i[1]) begin
        pre_flag <= 1'b0;
      end
    end
  end

  assign irq_o = pre_flag;
`else
  assign pre_flag = 1'b0;
  assign irq_o    = 1'b0;
`endif

endmodule
